multicycle_controller: RTL and testbench

- Main control FSM for the single-memory MIPS multi-cycle processor.
- Sequences each instruction through FETCH/DECODE/EXEC/MEM/WB.
- Drives every enable and mux select of the shared datapath: PC, memory, IR, register file, ALU.
- Inserts parameterised memory wait states and flags illegal opcodes.

---
 rtl/multicycle_controller_pkg.sv | 74 +++++++
 rtl/multicycle_controller_if.sv | 40 ++++
 rtl/multicycle_controller_alu_op_decoder.sv | 32 +++
 rtl/multicycle_controller.sv | 171 +++++++++++++++++
 tb/tb_multicycle_controller.sv | 213 +++++++++++++++++++++
 5 files changed

// File: rtl/multicycle_controller_pkg.sv
// multicycle_pkg: shared constants for the multi-cycle MIPS control path.
// Holds state encodings, opcode/funct values, ALUOp codes, datapath mux
// select values, the packed control-word struct and an opcode legality check.
package multicycle_pkg;

    typedef enum logic [2:0] {
        S_FETCH  = 3'd0,
        S_DECODE = 3'd1,
        S_EXEC   = 3'd2,
        S_MEM    = 3'd3,
        S_WB     = 3'd4
    } state_e;

    localparam logic [5:0] OP_RTYPE = 6'h00;
    localparam logic [5:0] OP_J     = 6'h02;
    localparam logic [5:0] OP_JAL   = 6'h03;
    localparam logic [5:0] OP_BEQ   = 6'h04;
    localparam logic [5:0] OP_BNE   = 6'h05;
    localparam logic [5:0] OP_ADDI  = 6'h08;
    localparam logic [5:0] OP_ADDIU = 6'h09;
    localparam logic [5:0] OP_SLTI  = 6'h0A;
    localparam logic [5:0] OP_SLTIU = 6'h0B;
    localparam logic [5:0] OP_ANDI  = 6'h0C;
    localparam logic [5:0] OP_ORI   = 6'h0D;
    localparam logic [5:0] OP_LUI   = 6'h0F;
    localparam logic [5:0] OP_LW    = 6'h23;
    localparam logic [5:0] OP_SW    = 6'h2B;

    localparam logic [5:0] FN_JR    = 6'h08;
    localparam logic [5:0] FN_JALR  = 6'h09;

    localparam logic [3:0] ALU_ADD   = 4'd0;
    localparam logic [3:0] ALU_SUB   = 4'd1;
    localparam logic [3:0] ALU_AND   = 4'd2;
    localparam logic [3:0] ALU_OR    = 4'd3;
    localparam logic [3:0] ALU_SLT   = 4'd4;
    localparam logic [3:0] ALU_SLTU  = 4'd5;
    localparam logic [3:0] ALU_FUNCT = 4'd15;  // ALU decodes IR funct itself

    localparam logic [1:0] RD_RT = 2'b00, RD_RD = 2'b01, RD_RA = 2'b10;
    localparam logic [1:0] M2R_ALU = 2'b00, M2R_MDR = 2'b01, M2R_PC = 2'b10;
    localparam logic [1:0] SRCB_B = 2'b00, SRCB_4 = 2'b01, SRCB_IMM = 2'b10, SRCB_IMM_SH2 = 2'b11;
    localparam logic [1:0] PCS_ALU = 2'b00, PCS_ALUOUT = 2'b01, PCS_JUMP = 2'b10, PCS_REG = 2'b11;

    // Full control word driven onto the datapath (state reported separately).
    typedef struct packed {
        logic       PCWrite;
        logic       PCWriteCond;
        logic       IorD;
        logic       MemRead;
        logic       MemWrite;
        logic       IRWrite;
        logic       RegWrite;
        logic [1:0] RegDst;
        logic [1:0] MemtoReg;
        logic       ALUSrcA;
        logic [1:0] ALUSrcB;
        logic       ExtOp;
        logic       LuiOp;
        logic [3:0] ALUOp;
        logic [1:0] PCSource;
        logic       instr_done;
        logic       illegal;
    } ctl_t;

    function automatic logic op_supported(input logic [5:0] op);
        case (op)
            OP_RTYPE, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_ADDIU, OP_SLTI,
            OP_SLTIU, OP_ANDI, OP_ORI, OP_LUI, OP_LW, OP_SW: return 1'b1;
            default: return 1'b0;
        endcase
    endfunction

endpackage

// File: rtl/multicycle_controller_if.sv
// multicycle_controller_if: bundle between the controller and the datapath.
// slave  = controller side: takes IR fields + Zero, drives controls and state.
// master = datapath side: the reverse.
interface multicycle_controller_if;
    logic [5:0] OpCode;
    logic [5:0] Funct;
    logic       Zero;
    logic       PCWrite;
    logic       PCWriteCond;
    logic       IorD;
    logic       MemRead;
    logic       MemWrite;
    logic       IRWrite;
    logic       RegWrite;
    logic [1:0] RegDst;
    logic [1:0] MemtoReg;
    logic       ALUSrcA;
    logic [1:0] ALUSrcB;
    logic       ExtOp;
    logic       LuiOp;
    logic [3:0] ALUOp;
    logic [1:0] PCSource;
    logic       instr_done;
    logic       illegal;
    logic [2:0] state;

    modport slave (
        input  OpCode, Funct, Zero,
        output PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
               RegDst, MemtoReg, ALUSrcA, ALUSrcB, ExtOp, LuiOp, ALUOp, PCSource,
               instr_done, illegal, state
    );

    modport master (
        output OpCode, Funct, Zero,
        input  PCWrite, PCWriteCond, IorD, MemRead, MemWrite, IRWrite, RegWrite,
               RegDst, MemtoReg, ALUSrcA, ALUSrcB, ExtOp, LuiOp, ALUOp, PCSource,
               instr_done, illegal, state
    );
endinterface

// File: rtl/multicycle_controller_alu_op_decoder.sv
// alu_op_decoder: combinational map of (state, OpCode) to ALUOp, ExtOp, LuiOp.
// Ports: state_i (FSM state), opcode_i (IR[31:26]);
//        alu_op_o, ext_op_o (sign extend), lui_op_o (imm<<16 select).
// FETCH/DECODE always add; only EXEC is opcode dependent; MEM/WB leave all 0.
module alu_op_decoder
    import multicycle_pkg::*;
(
    input  state_e     state_i,
    input  logic [5:0] opcode_i,
    output logic [3:0] alu_op_o,
    output logic       ext_op_o,
    output logic       lui_op_o
);
    always_comb begin
        alu_op_o = ALU_ADD;
        ext_op_o = 1'b0;
        lui_op_o = 1'b0;
        if (state_i == S_EXEC) begin
            case (opcode_i)
                OP_RTYPE:                    alu_op_o = ALU_FUNCT;
                OP_BEQ, OP_BNE:              alu_op_o = ALU_SUB;
                OP_SLTI:  begin alu_op_o = ALU_SLT;  ext_op_o = 1'b1; end
                OP_SLTIU: begin alu_op_o = ALU_SLTU; ext_op_o = 1'b1; end
                OP_ANDI:                     alu_op_o = ALU_AND;
                OP_ORI:                      alu_op_o = ALU_OR;
                OP_ADDI, OP_ADDIU, OP_LW, OP_SW: ext_op_o = 1'b1;
                OP_LUI:                      lui_op_o = 1'b1;
                default: ;
            endcase
        end
    end
endmodule

// File: rtl/multicycle_controller.sv
// multicycle_controller: main control FSM of the single-memory multi-cycle MIPS.
// Ports: clk, reset (async, active high); bus (slave modport) carrying
//        OpCode/Funct/Zero in and every datapath enable/select, instr_done,
//        illegal and the debug state out.
// FETCH and MEM each stretch to MEM_LATENCY+1 cycles via a 4-bit wait counter.
module multicycle_controller
    import multicycle_pkg::*;
#(
    parameter int MEM_LATENCY = 0
) (
    input  logic                  clk,
    input  logic                  reset,
    multicycle_controller_if.slave bus
);
    state_e     state_q, state_d;
    logic [3:0] wait_q, wait_d;
    logic       last;
    logic [3:0] alu_op;
    logic       ext_op, lui_op;
    ctl_t       ctl, ctl_o;

    assign last = (wait_q == MEM_LATENCY[3:0]);

    alu_op_decoder u_alu_op_decoder (
        .state_i  (state_q),
        .opcode_i (bus.OpCode),
        .alu_op_o (alu_op),
        .ext_op_o (ext_op),
        .lui_op_o (lui_op)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= S_FETCH;
            wait_q  <= '0;
        end else begin
            state_q <= state_d;
            wait_q  <= wait_d;
        end
    end

    always_comb begin
        state_d   = state_q;
        wait_d    = '0;
        ctl       = '0;
        ctl.ALUOp = alu_op;
        ctl.ExtOp = ext_op;
        ctl.LuiOp = lui_op;
        case (state_q)
            S_FETCH: begin
                ctl.MemRead = 1'b1;
                ctl.ALUSrcB = SRCB_4;
                if (last) begin
                    ctl.IRWrite = 1'b1;
                    ctl.PCWrite = 1'b1;
                    state_d     = S_DECODE;
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_DECODE: begin
                // Speculative branch target into ALUOut for beq/bne.
                ctl.ALUSrcB = SRCB_IMM_SH2;
                state_d     = S_EXEC;
                if (!op_supported(bus.OpCode)) begin
                    ctl.illegal    = 1'b1;
                    ctl.instr_done = 1'b1;
                    state_d        = S_FETCH;
                end else if (bus.OpCode == OP_J || bus.OpCode == OP_JAL) begin
                    ctl.PCSource   = PCS_JUMP;
                    ctl.PCWrite    = 1'b1;
                    ctl.instr_done = 1'b1;
                    state_d        = S_FETCH;
                    if (bus.OpCode == OP_JAL) begin
                        ctl.RegWrite = 1'b1;
                        ctl.RegDst   = RD_RA;
                        ctl.MemtoReg = M2R_PC;
                    end
                end else if (bus.OpCode == OP_RTYPE &&
                             (bus.Funct == FN_JR || bus.Funct == FN_JALR)) begin
                    ctl.PCSource   = PCS_REG;
                    ctl.PCWrite    = 1'b1;
                    ctl.instr_done = 1'b1;
                    state_d        = S_FETCH;
                    if (bus.Funct == FN_JALR) begin
                        ctl.RegWrite = 1'b1;
                        ctl.RegDst   = RD_RD;
                        ctl.MemtoReg = M2R_PC;
                    end
                end
            end
            S_EXEC: begin
                case (bus.OpCode)
                    OP_RTYPE: begin
                        ctl.ALUSrcA = 1'b1;
                        state_d     = S_WB;
                    end
                    OP_BEQ, OP_BNE: begin
                        ctl.ALUSrcA     = 1'b1;
                        ctl.PCSource    = PCS_ALUOUT;
                        ctl.PCWriteCond = (bus.OpCode == OP_BEQ);
                        ctl.PCWrite     = (bus.OpCode == OP_BNE) && !bus.Zero;
                        ctl.instr_done  = 1'b1;
                        state_d         = S_FETCH;
                    end
                    OP_LW, OP_SW: begin
                        ctl.ALUSrcA = 1'b1;
                        ctl.ALUSrcB = SRCB_IMM;
                        state_d     = S_MEM;
                    end
                    OP_LUI: begin
                        ctl.ALUSrcB = SRCB_IMM;
                        state_d     = S_WB;
                    end
                    default: begin  // immediate arithmetic/logic
                        ctl.ALUSrcA = 1'b1;
                        ctl.ALUSrcB = SRCB_IMM;
                        state_d     = S_WB;
                    end
                endcase
            end
            S_MEM: begin
                ctl.IorD    = 1'b1;
                ctl.MemRead = (bus.OpCode == OP_LW);
                if (last) begin
                    if (bus.OpCode == OP_LW) begin
                        state_d = S_WB;
                    end else begin
                        // Single write strobe once the memory is ready.
                        ctl.MemWrite   = 1'b1;
                        ctl.instr_done = 1'b1;
                        state_d        = S_FETCH;
                    end
                end else begin
                    wait_d = wait_q + 4'd1;
                end
            end
            S_WB: begin
                ctl.RegWrite   = 1'b1;
                ctl.RegDst     = (bus.OpCode == OP_RTYPE) ? RD_RD : RD_RT;
                ctl.MemtoReg   = (bus.OpCode == OP_LW) ? M2R_MDR : M2R_ALU;
                ctl.instr_done = 1'b1;
                state_d        = S_FETCH;
            end
            default: state_d = S_FETCH;
        endcase
    end

    // Everything but the state is forced quiet while reset is held.
    assign ctl_o = reset ? '0 : ctl;

    assign bus.PCWrite     = ctl_o.PCWrite;
    assign bus.PCWriteCond = ctl_o.PCWriteCond;
    assign bus.IorD        = ctl_o.IorD;
    assign bus.MemRead     = ctl_o.MemRead;
    assign bus.MemWrite    = ctl_o.MemWrite;
    assign bus.IRWrite     = ctl_o.IRWrite;
    assign bus.RegWrite    = ctl_o.RegWrite;
    assign bus.RegDst      = ctl_o.RegDst;
    assign bus.MemtoReg    = ctl_o.MemtoReg;
    assign bus.ALUSrcA     = ctl_o.ALUSrcA;
    assign bus.ALUSrcB     = ctl_o.ALUSrcB;
    assign bus.ExtOp       = ctl_o.ExtOp;
    assign bus.LuiOp       = ctl_o.LuiOp;
    assign bus.ALUOp       = ctl_o.ALUOp;
    assign bus.PCSource    = ctl_o.PCSource;
    assign bus.instr_done  = ctl_o.instr_done;
    assign bus.illegal     = ctl_o.illegal;
    assign bus.state       = state_q;

endmodule

// File: tb/tb_multicycle_controller.sv
// Bench for multicycle_controller: two instances (MEM_LATENCY 0 and 2).
// Each instruction is expanded into a per-cycle schedule of expected control
// words from its class and the latency, then compared cycle by cycle.
module tb_multicycle_controller;
    import multicycle_pkg::*;

    logic clk = 1'b0;
    logic reset = 1'b1;
    always #5 clk = ~clk;

    typedef struct packed {
        logic pcw, pcwc, iord, mrd, mwr, irw, rw;
        logic [1:0] rdst, m2r;
        logic asa;
        logic [1:0] asb;
        logic ext, lui;
        logic [3:0] aop;
        logic [1:0] pcs;
        logic done, ill;
        logic [2:0] st;
    } exp_t;

    typedef enum {C_R, C_JR, C_JALR, C_J, C_JAL, C_BEQ, C_BNE, C_IAR, C_LUI, C_LW, C_SW, C_ILL} cls_e;

    logic [5:0] op_d [2];
    logic [5:0] fn_d [2];
    logic       z_d  [2];
    exp_t       obs  [2];
    exp_t       q [$];
    int         n_cmp = 0;
    int         n_bad = 0;

    multicycle_controller_if if0 ();
    multicycle_controller_if if1 ();

    multicycle_controller #(.MEM_LATENCY(0)) dut0 (.clk(clk), .reset(reset), .bus(if0));
    multicycle_controller #(.MEM_LATENCY(2)) dut1 (.clk(clk), .reset(reset), .bus(if1));

    assign if0.OpCode = op_d[0];
    assign if0.Funct  = fn_d[0];
    assign if0.Zero   = z_d[0];
    assign if1.OpCode = op_d[1];
    assign if1.Funct  = fn_d[1];
    assign if1.Zero   = z_d[1];

    assign obs[0] = {if0.PCWrite, if0.PCWriteCond, if0.IorD, if0.MemRead, if0.MemWrite, if0.IRWrite,
                     if0.RegWrite, if0.RegDst, if0.MemtoReg, if0.ALUSrcA, if0.ALUSrcB, if0.ExtOp,
                     if0.LuiOp, if0.ALUOp, if0.PCSource, if0.instr_done, if0.illegal, if0.state};
    assign obs[1] = {if1.PCWrite, if1.PCWriteCond, if1.IorD, if1.MemRead, if1.MemWrite, if1.IRWrite,
                     if1.RegWrite, if1.RegDst, if1.MemtoReg, if1.ALUSrcA, if1.ALUSrcB, if1.ExtOp,
                     if1.LuiOp, if1.ALUOp, if1.PCSource, if1.instr_done, if1.illegal, if1.state};

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    function automatic cls_e classify(input logic [5:0] op, input logic [5:0] fn);
        case (op)
            6'h00: return (fn == 6'h08) ? C_JR : (fn == 6'h09) ? C_JALR : C_R;
            6'h02: return C_J;
            6'h03: return C_JAL;
            6'h04: return C_BEQ;
            6'h05: return C_BNE;
            6'h08, 6'h09, 6'h0A, 6'h0B, 6'h0C, 6'h0D: return C_IAR;
            6'h0F: return C_LUI;
            6'h23: return C_LW;
            6'h2B: return C_SW;
            default: return C_ILL;
        endcase
    endfunction

    // Expected control-word schedule for one instruction.
    task automatic build(input logic [5:0] op, input logic [5:0] fn, input logic z, input int lat);
        cls_e c = classify(op, fn);
        exp_t r;
        q.delete();
        for (int i = 0; i <= lat; i++) begin
            r = '0; r.st = 3'd0; r.mrd = 1; r.asb = 2'b01; r.aop = ALU_ADD;
            if (i == lat) begin r.irw = 1; r.pcw = 1; end
            q.push_back(r);
        end
        r = '0; r.st = 3'd1; r.asb = 2'b11; r.aop = ALU_ADD;
        case (c)
            C_J, C_JAL: begin r.pcs = 2'b10; r.pcw = 1; r.done = 1; end
            C_JR, C_JALR: begin r.pcs = 2'b11; r.pcw = 1; r.done = 1; end
            C_ILL: begin r.ill = 1; r.done = 1; end
            default: ;
        endcase
        if (c == C_JAL)  begin r.rw = 1; r.rdst = 2'b10; r.m2r = 2'b10; end
        if (c == C_JALR) begin r.rw = 1; r.rdst = 2'b01; r.m2r = 2'b10; end
        q.push_back(r);
        if (r.done) return;
        r = '0; r.st = 3'd2;
        case (c)
            C_R: begin r.asa = 1; r.aop = ALU_FUNCT; end
            C_IAR: begin
                r.asa = 1; r.asb = 2'b10;
                case (op)
                    6'h0A: begin r.aop = ALU_SLT;  r.ext = 1; end
                    6'h0B: begin r.aop = ALU_SLTU; r.ext = 1; end
                    6'h0C: r.aop = ALU_AND;
                    6'h0D: r.aop = ALU_OR;
                    default: begin r.aop = ALU_ADD; r.ext = 1; end
                endcase
            end
            C_LUI: begin r.lui = 1; r.asb = 2'b10; end
            C_LW, C_SW: begin r.asa = 1; r.asb = 2'b10; r.ext = 1; r.aop = ALU_ADD; end
            default: begin  // beq / bne
                r.asa = 1; r.aop = ALU_SUB; r.pcs = 2'b01; r.done = 1;
                if (c == C_BEQ) r.pcwc = 1; else r.pcw = !z;
            end
        endcase
        q.push_back(r);
        if (r.done) return;
        if (c == C_LW || c == C_SW) begin
            for (int i = 0; i <= lat; i++) begin
                r = '0; r.st = 3'd3; r.iord = 1;
                if (c == C_LW) r.mrd = 1;
                else if (i == lat) begin r.mwr = 1; r.done = 1; end
                q.push_back(r);
            end
            if (c == C_SW) return;
        end
        r = '0; r.st = 3'd4; r.rw = 1; r.done = 1;
        if (c == C_R) r.rdst = 2'b01;
        if (c == C_LW) r.m2r = 2'b01;
        q.push_back(r);
    endtask

    // Runs one instruction on DUT d; stop_at>0 aborts after that many cycles.
    // Entered and left at posedge+1.
    task automatic run(input int d, input logic [5:0] op, input logic [5:0] fn, input logic z,
                       input int stop_at, input string tag);
        build(op, fn, z, (d == 0) ? 0 : 2);
        op_d[d] = op; fn_d[d] = fn; z_d[d] = z;
        for (int i = 0; i < q.size(); i++) begin
            if (stop_at > 0 && i == stop_at) break;
            #1;
            chk($sformatf("%s op%h c%0d", tag, op, i), obs[d], q[i]);
            @(posedge clk); #1;
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk("reset dut0", obs[0], '0);
        chk("reset dut1", obs[1], '0);
        reset = 1'b0;
    endtask

    task automatic rand_instrs(input int d, input int n);
        logic [5:0] legal [14] = '{6'h00, 6'h02, 6'h03, 6'h04, 6'h05, 6'h08, 6'h09,
                                    6'h0A, 6'h0B, 6'h0C, 6'h0D, 6'h0F, 6'h23, 6'h2B};
        logic [5:0] op, fn;
        for (int k = 0; k < n; k++) begin
            op = ($urandom_range(0, 9) < 8) ? legal[$urandom_range(0, 13)] : 6'($urandom);
            fn = 6'($urandom);
            if (op == 6'h00 && $urandom_range(0, 3) == 0) fn = 6'h08 + 6'($urandom_range(0, 1));
            run(d, op, fn, 1'($urandom), 0, "rand");
        end
    endtask

    initial begin
        for (int i = 0; i < 2; i++) begin op_d[i] = '0; fn_d[i] = '0; z_d[i] = 1'b0; end

        // Latency 0 instance
        do_reset();
        run(0, 6'h23, 6'h00, 1'b0, 0, "lw");
        run(0, 6'h04, 6'h00, 1'b1, 0, "beq z1");
        run(0, 6'h04, 6'h00, 1'b0, 0, "beq z0");
        run(0, 6'h05, 6'h00, 1'b1, 0, "bne z1");
        run(0, 6'h05, 6'h00, 1'b0, 0, "bne z0");
        run(0, 6'h03, 6'h00, 1'b0, 0, "jal");
        run(0, 6'h3F, 6'h00, 1'b0, 0, "illegal");
        run(0, 6'h00, 6'h09, 1'b0, 0, "jalr");
        run(0, 6'h0F, 6'h00, 1'b0, 0, "lui");
        rand_instrs(0, 60);

        // Latency 2 instance
        do_reset();
        run(1, 6'h2B, 6'h00, 1'b0, 0, "sw L2");
        run(1, 6'h23, 6'h00, 1'b0, 0, "lw L2");
        rand_instrs(1, 60);

        // Reset in the middle of a stretched MEM: 3 FETCH + DECODE + EXEC + 2 MEM
        run(1, 6'h23, 6'h00, 1'b0, 7, "lw cut");
        reset = 1'b1;
        #1;
        chk("async reset mid MEM", obs[1], '0);
        @(posedge clk); #1;
        chk("reset held", obs[1], '0);
        reset = 1'b0;
        run(1, 6'h2B, 6'h00, 1'b0, 0, "sw after reset");
        run(1, 6'h00, 6'h20, 1'b0, 0, "add after reset");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // Hard stop in case something stalls the sequence above.
    initial begin
        #200000;
        $display("FAIL timeout: got no summary, expected completion");
        $fatal(1, "timeout");
    end

endmodule
